// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed big-endian data memory with valid/ready handshake and fault reporting
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned W/H/HU accesses into faults (code 01).
module dmem_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_fault_code
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] M_W  = 3'd0;
    localparam logic [2:0] M_H  = 3'd1;
    localparam logic [2:0] M_HU = 3'd2;
    localparam logic [2:0] M_B  = 3'd3;
    localparam logic [2:0] M_BU = 3'd4;

    logic [1:0]            state;
    logic [1:0]            cnt;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic                  accept;
    logic                  illegal, out_of_range, misaligned, faulted;
    logic [1:0]            fault_code;
    logic [31:0]           load_data;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid & req_ready;

    // Byte indices wrap modulo DEPTH by truncation to ADDR_WIDTH bits.
    assign a0 = req_addr[ADDR_WIDTH-1:0];
    assign a1 = a0 + ADDR_WIDTH'(1);
    assign a2 = a0 + ADDR_WIDTH'(2);
    assign a3 = a0 + ADDR_WIDTH'(3);

    assign illegal      = (req_mode > M_BU);
    assign out_of_range = (req_addr[31:ADDR_WIDTH] != '0);
`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((req_mode == M_W) && (req_addr[1:0] != 2'b00)) ||
                        (((req_mode == M_H) || (req_mode == M_HU)) && req_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        fault_code = 2'b00;
        if (illegal)
            fault_code = 2'b11;
        else if (out_of_range)
            fault_code = 2'b10;
        else if (misaligned)
            fault_code = 2'b01;
    end

    assign faulted = (fault_code != 2'b00);

    always_comb begin
        load_data = '0;
        case (req_mode)
            M_W:  load_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
            M_H:  load_data = {{16{mem[a0][7]}}, mem[a0], mem[a1]};
            M_HU: load_data = {16'h0000, mem[a0], mem[a1]};
            M_B:  load_data = {{24{mem[a0][7]}}, mem[a0]};
            M_BU: load_data = {24'h000000, mem[a0]};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rsp_rdata      <= '0;
            rsp_fault      <= 1'b0;
            rsp_fault_code <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rsp_rdata      <= (faulted || req_write) ? 32'h0 : load_data;
                        rsp_fault      <= faulted;
                        rsp_fault_code <= fault_code;
                        cnt            <= 2'(READ_LATENCY - 1);
                        state          <= (READ_LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1)
                        state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage clears with the controller so a store in flight at reset is wiped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (accept && req_write && !faulted) begin
            case (req_mode)
                M_W: begin
                    mem[a0] <= req_wdata[31:24];
                    mem[a1] <= req_wdata[23:16];
                    mem[a2] <= req_wdata[15:8];
                    mem[a3] <= req_wdata[7:0];
                end
                M_H, M_HU: begin
                    mem[a0] <= req_wdata[15:8];
                    mem[a1] <= req_wdata[7:0];
                end
                M_B, M_BU: mem[a0] <= req_wdata[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl (instance 0: latency 1, instance 1: latency 3)
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [2:0]  req_mode  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_fault [2];
    logic [1:0]  rsp_fault_code [2];

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_WIDTH(12), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_mode(req_mode[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_fault(rsp_fault[0]), .rsp_fault_code(rsp_fault_code[0])
    );

    dmem_ctrl #(.ADDR_WIDTH(12), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_mode(req_mode[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_fault(rsp_fault[1]), .rsp_fault_code(rsp_fault_code[1])
    );

    // One request/response; lat counts edges after the accept edge before rsp_valid is seen.
    task automatic xact(input int w, input logic wr, input logic [2:0] md, input logic [31:0] ad,
                        input logic [31:0] wd, output logic [31:0] rd, output logic f,
                        output logic [1:0] fc, output int lat);
        @(negedge clk);
        req_valid[w] = 1'b1; req_write[w] = wr; req_mode[w] = md;
        req_addr[w] = ad; req_wdata[w] = wd; rsp_ready[w] = 1'b1;
        @(posedge clk);
        #1 req_valid[w] = 1'b0;
        lat = 0;
        while (!rsp_valid[w] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (!rsp_valid[w]) $display("FAIL rsp_timeout dut=%0d rsp_valid=0 required=1", w);
        else pass_cnt++;
        rd = rsp_rdata[w]; f = rsp_fault[w]; fc = rsp_fault_code[w];
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_write[i] = 0; req_mode[i] = 0;
            req_addr[i] = 0; req_wdata[i] = 0; rsp_ready[i] = 1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (req_ready[i] !== 1'b1) $display("FAIL reset_req_ready dut=%0d got=%b exp=1", i, req_ready[i]);
            else pass_cnt++;
            total_cnt++;
            if (rsp_valid[i] !== 1'b0) $display("FAIL reset_rsp_valid dut=%0d got=%b exp=0", i, rsp_valid[i]);
            else pass_cnt++;
            total_cnt++;
            if ({rsp_rdata[i], rsp_fault[i], rsp_fault_code[i]} !== 35'h0)
                $display("FAIL reset_rsp_fields dut=%0d got=%h/%b/%b exp=0/0/00", i, rsp_rdata[i], rsp_fault[i], rsp_fault_code[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic f; logic [1:0] fc; int lat;
        xact(0, 1, 3'd0, 32'h010, 32'h11223344, rd, f, fc, lat);
        total_cnt++;
        if ({rd, f, fc} !== 35'h0) $display("FAIL store_rsp got=%h/%b/%b exp=0/0/00", rd, f, fc);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 0) $display("FAIL latency_l1 got=%0d exp=0", lat);
        else pass_cnt++;
        xact(0, 0, 3'd0, 32'h010, 0, rd, f, fc, lat);
        total_cnt++;
        if (rd !== 32'h11223344) $display("FAIL load_w got=%h exp=11223344", rd);
        else pass_cnt++;
        xact(0, 0, 3'd4, 32'h010, 0, rd, f, fc, lat);
        total_cnt++;
        if (rd !== 32'h11) $display("FAIL byte_010 got=%h exp=00000011", rd);
        else pass_cnt++;
        xact(0, 0, 3'd4, 32'h013, 0, rd, f, fc, lat);
        total_cnt++;
        if (rd !== 32'h44) $display("FAIL byte_013 got=%h exp=00000044", rd);
        else pass_cnt++;
    endtask

    task automatic test_extension;
        logic [31:0] rd; logic f; logic [1:0] fc; int lat;
        logic [2:0]  md  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [31:0] ad  [5] = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h0};
        logic [31:0] exp [5] = '{32'hFFFF80FF, 32'h000080FF, 32'hFFFFFFFF, 32'h000000FF, 32'h80FF7F01};
        xact(0, 1, 3'd0, 32'h0, 32'h80FF7F01, rd, f, fc, lat);
        for (int i = 0; i < 5; i++) begin
            xact(0, 0, md[i], ad[i], 0, rd, f, fc, lat);
            total_cnt++;
            if (rd !== exp[i]) $display("FAIL ext_load_%0d got=%h exp=%h", i, rd, exp[i]);
            else pass_cnt++;
        end
        xact(0, 1, 3'd3, 32'h2, 32'h000000AB, rd, f, fc, lat);
        xact(0, 0, 3'd0, 32'h0, 0, rd, f, fc, lat);
        total_cnt++;
        if (rd !== 32'h80FFAB01) $display("FAIL byte_store_merge got=%h exp=80FFAB01", rd);
        else pass_cnt++;
    endtask

    task automatic test_faults;
        logic [31:0] rd; logic f; logic [1:0] fc; int lat;
        xact(0, 0, 3'd0, 32'h002, 0, rd, f, fc, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        total_cnt++;
        if ({rd, f, fc} !== {32'h0, 1'b1, 2'b01}) $display("FAIL misaligned got=%h/%b/%b exp=0/1/01", rd, f, fc);
        else pass_cnt++;
`else
        total_cnt++;
        if ({rd, f, fc} !== {32'hAB010000, 1'b0, 2'b00}) $display("FAIL misaligned got=%h/%b/%b exp=AB010000/0/00", rd, f, fc);
        else pass_cnt++;
`endif
        xact(0, 1, 3'd0, 32'h1000, 32'h55555555, rd, f, fc, lat);
        total_cnt++;
        if ({rd, f, fc} !== {32'h0, 1'b1, 2'b10}) $display("FAIL out_of_range got=%h/%b/%b exp=0/1/10", rd, f, fc);
        else pass_cnt++;
        xact(0, 1, 3'd5, 32'h0, 32'h66666666, rd, f, fc, lat);
        total_cnt++;
        if ({rd, f, fc} !== {32'h0, 1'b1, 2'b11}) $display("FAIL illegal_mode got=%h/%b/%b exp=0/1/11", rd, f, fc);
        else pass_cnt++;
        xact(0, 0, 3'd5, 32'h1001, 0, rd, f, fc, lat);
        total_cnt++;
        if ({f, fc} !== 3'b111) $display("FAIL fault_priority got=%b/%b exp=1/11", f, fc);
        else pass_cnt++;
        xact(0, 0, 3'd0, 32'h0, 0, rd, f, fc, lat);
        total_cnt++;
        if (rd !== 32'h80FFAB01) $display("FAIL fault_no_write got=%h exp=80FFAB01", rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        req_valid[0] = 1; req_write[0] = 0; req_mode[0] = 3'd0; req_addr[0] = 32'h010; rsp_ready[0] = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (rsp_valid[0] !== exp_v[i] || req_ready[0] !== ~exp_v[i])
                $display("FAIL b2b_cycle_%0d rsp_valid=%b req_ready=%b exp=%b/%b", i, rsp_valid[0], req_ready[0], exp_v[i], ~exp_v[i]);
            else pass_cnt++;
        end
        req_valid[0] = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        logic [31:0] rd; logic f; logic [1:0] fc; int lat;
        xact(1, 1, 3'd0, 32'h020, 32'hDEADBEEF, rd, f, fc, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL latency_l3 got=%0d exp=2", lat);
        else pass_cnt++;
        @(negedge clk);
        req_valid[1] = 1; req_write[1] = 0; req_mode[1] = 3'd0; req_addr[1] = 32'h020; rsp_ready[1] = 0;
        @(posedge clk); #1 req_valid[1] = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (rsp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 || rsp_rdata[1] !== 32'hDEADBEEF || rsp_fault[1] !== 1'b0)
                $display("FAIL backpressure_%0d got=%b/%b/%h exp=1/0/deadbeef", i, rsp_valid[1], req_ready[1], rsp_rdata[1]);
            else pass_cnt++;
        end
        rsp_ready[1] = 1;
        @(posedge clk); #1;
        total_cnt++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
            $display("FAIL release got=%b/%b exp=0/1", rsp_valid[1], req_ready[1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic f; logic [1:0] fc; int lat; int seen;
        // Reset while a response is being held: rsp_valid must drop without a clock edge.
        @(negedge clk);
        req_valid[1] = 1; req_write[1] = 0; req_mode[1] = 3'd0; req_addr[1] = 32'h020; rsp_ready[1] = 0;
        @(posedge clk); #1 req_valid[1] = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (rsp_valid[1] !== 1'b0) $display("FAIL reset_async_drop got=%b exp=0", rsp_valid[1]);
        else pass_cnt++;
        @(negedge clk) reset = 1'b0;
        rsp_ready[1] = 1;
        // Store accepted, then reset during WAIT.
        @(negedge clk);
        req_valid[1] = 1; req_write[1] = 1; req_mode[1] = 3'd0; req_addr[1] = 32'h010; req_wdata[1] = 32'hCAFEF00D;
        @(posedge clk); #1 req_valid[1] = 0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_wait_no_rsp got=%0d cycles exp=0", seen);
        else pass_cnt++;
        xact(1, 0, 3'd0, 32'h010, 0, rd, f, fc, lat);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL reset_wipes_store got=%h exp=00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
`ifndef DMEM_ALIGN_CHECK_EN
        logic [31:0] rd; logic f; logic [1:0] fc; int lat;
        logic [31:0] ad  [4] = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
        logic [31:0] exp [4] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        xact(0, 1, 3'd0, 32'hFFE, 32'hA1B2C3D4, rd, f, fc, lat);
        for (int i = 0; i < 4; i++) begin
            xact(0, 0, 3'd4, ad[i], 0, rd, f, fc, lat);
            total_cnt++;
            if (rd !== exp[i]) $display("FAIL wrap_byte_%0d got=%h exp=%h", i, rd, exp[i]);
            else pass_cnt++;
        end
`endif
    endtask

    initial begin
        test_reset;
        test_word;
        test_extension;
        test_faults;
        test_back_to_back;
        test_latency;
        test_reset_mid;
        test_wrap;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
